// File: rtl/uparc_ifu_if.sv
// Fetch-stage and instruction-bus signals of the uparc instruction fetch unit.
// Widths come from UPARC_ADDR_WIDTH, UPARC_INSTR_WIDTH and UPARC_DATA_WIDTH.
`ifndef UPARC_ADDR_WIDTH
`define UPARC_ADDR_WIDTH 32
`endif
`ifndef UPARC_INSTR_WIDTH
`define UPARC_INSTR_WIDTH 32
`endif
`ifndef UPARC_DATA_WIDTH
`define UPARC_DATA_WIDTH 32
`endif

interface uparc_ifu_if;
    logic [`UPARC_ADDR_WIDTH-1:0]  i_addr;
    logic                          i_rd_cmd;
    logic [`UPARC_INSTR_WIDTH-1:0] o_instr_dat;
    logic                          o_busy;
    logic                          o_err_align;
    logic                          o_err_bus;
    logic [`UPARC_ADDR_WIDTH-1:0]  o_bus_addr;
    logic                          o_bus_rd;
    logic                          i_bus_ready;
    logic [`UPARC_DATA_WIDTH-1:0]  i_bus_rdata;
    logic                          i_bus_rvalid;
    logic                          i_bus_err;

    // master: fetch stage plus memory side; slave: the fetch unit itself
    modport master (
        output i_addr, i_rd_cmd, i_bus_ready, i_bus_rdata, i_bus_rvalid, i_bus_err,
        input  o_instr_dat, o_busy, o_err_align, o_err_bus, o_bus_addr, o_bus_rd
    );
    modport slave (
        input  i_addr, i_rd_cmd, i_bus_ready, i_bus_rdata, i_bus_rvalid, i_bus_err,
        output o_instr_dat, o_busy, o_err_align, o_err_bus, o_bus_addr, o_bus_rd
    );
endinterface

// File: rtl/uparc_ifu.sv
// Instruction fetch unit: one outstanding bus read per fetch request.
// Optional last-address hit bypass enabled by defining UPARC_IFU_LASTHIT_EN.
`ifndef UPARC_ADDR_WIDTH
`define UPARC_ADDR_WIDTH 32
`endif
`ifndef UPARC_INSTR_WIDTH
`define UPARC_INSTR_WIDTH 32
`endif
`ifndef UPARC_DATA_WIDTH
`define UPARC_DATA_WIDTH 32
`endif

module uparc_ifu (
    input  logic          clk,
    input  logic          nrst,
    uparc_ifu_if.slave    ifu
);
    localparam int AW = `UPARC_ADDR_WIDTH;
    localparam int IW = `UPARC_INSTR_WIDTH;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t          r_state;
    logic [IW-1:0]   r_instr;
    logic [AW-1:0]   r_bus_addr;
    logic            r_bus_rd;
    logic            r_err_align;
    logic            r_err_bus;

    logic            w_aligned;
    logic            w_hit;

    assign w_aligned = (ifu.i_addr[1:0] == 2'b00);

`ifdef UPARC_IFU_LASTHIT_EN
    logic [AW-1:0]   r_tag;
    logic            r_tag_vld;

    assign w_hit = (r_state == IDLE) && ifu.i_rd_cmd && w_aligned &&
                   r_tag_vld && (ifu.i_addr == r_tag);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_tag     <= '0;
            r_tag_vld <= 1'b0;
        end else if (r_state == WAIT) begin
            if (ifu.i_bus_err) begin
                r_tag_vld <= 1'b0;
            end else if (ifu.i_bus_rvalid) begin
                r_tag     <= r_bus_addr;
                r_tag_vld <= 1'b1;
            end
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= IDLE;
            r_instr     <= '0;
            r_bus_addr  <= '0;
            r_bus_rd    <= 1'b0;
            r_err_align <= 1'b0;
            r_err_bus   <= 1'b0;
        end else begin
            r_err_align <= 1'b0;
            r_err_bus   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (ifu.i_rd_cmd) begin
                        if (!w_aligned) begin
                            r_err_align <= 1'b1;
                        end else if (!w_hit) begin
                            r_bus_addr <= ifu.i_addr;
                            r_bus_rd   <= 1'b1;
                            r_state    <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (ifu.i_bus_ready) begin
                        r_bus_rd <= 1'b0;
                        r_state  <= WAIT;
                    end
                end
                WAIT: begin
                    // an error response wins over a simultaneous rvalid and yields a NOP
                    if (ifu.i_bus_err) begin
                        r_instr   <= '0;
                        r_err_bus <= 1'b1;
                        r_state   <= IDLE;
                    end else if (ifu.i_bus_rvalid) begin
                        r_instr <= IW'(ifu.i_bus_rdata);
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_bus_rd <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign ifu.o_busy      = (ifu.i_rd_cmd && w_aligned && !w_hit) || (r_state != IDLE);
    assign ifu.o_instr_dat = r_instr;
    assign ifu.o_bus_addr  = r_bus_addr;
    assign ifu.o_bus_rd    = r_bus_rd;
    assign ifu.o_err_align = r_err_align;
    assign ifu.o_err_bus   = r_err_bus;

endmodule

// File: doc/uparc_ifu.md
UPARC_IFU -- requirements
Module: uparc_ifu

Interface
REQ-001 The block SHALL have no parameters; widths SHALL come from UPARC_ADDR_WIDTH (AW), UPARC_INSTR_WIDTH (IW, 32) and UPARC_DATA_WIDTH (DW, 32).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 nrst  input  1  reset, asynchronous, active-low.
REQ-004 i_addr  input  AW  fetch address from the fetch stage, valid when i_rd_cmd=1.
REQ-005 i_rd_cmd  input  1  one-cycle fetch request from the fetch stage.
REQ-006 o_instr_dat  output  IW  fetched instruction, registered.
REQ-007 o_busy  output  1  fetch in progress; the fetch stage stalls while high.
REQ-008 o_err_align  output  1  one-cycle pulse: misaligned fetch address.
REQ-009 o_err_bus  output  1  one-cycle pulse: bus error on fetch.
REQ-010 o_bus_addr  output  AW  bus read address, registered.
REQ-011 o_bus_rd  output  1  bus read request, held until accepted.
REQ-012 i_bus_ready  input  1  bus accepts the request in the cycle where o_bus_rd=1 and i_bus_ready=1.
REQ-013 i_bus_rdata  input  DW  read data, valid with i_bus_rvalid.
REQ-014 i_bus_rvalid  input  1  read response valid, one cycle.
REQ-015 i_bus_err  input  1  error response, one cycle, replaces i_bus_rvalid.

Function
REQ-016 The FSM SHALL have states IDLE, REQ and WAIT.
REQ-017 o_busy SHALL equal (i_rd_cmd AND aligned AND NOT hit) OR (state != IDLE), combinationally.
REQ-018 aligned SHALL be i_addr[1:0]==2'b00; hit SHALL be 0 unless UPARC_IFU_LASTHIT_EN is defined.
REQ-019 In IDLE, an aligned non-hit i_rd_cmd SHALL latch i_addr into o_bus_addr and move to REQ.
REQ-020 In IDLE, a misaligned i_rd_cmd SHALL pulse o_err_align in the next cycle, start no bus transaction and stay in IDLE.
REQ-021 In REQ, o_bus_rd SHALL be 1 and o_bus_addr stable; if i_bus_ready=1, the FSM SHALL move to WAIT.
REQ-022 o_bus_rd SHALL be 0 in every state other than REQ.
REQ-023 In WAIT, i_bus_rvalid SHALL load i_bus_rdata into o_instr_dat and move to IDLE.
REQ-024 In WAIT, i_bus_err SHALL load 0 (NOP) into o_instr_dat, pulse o_err_bus in the next cycle and move to IDLE.
REQ-025 If i_bus_rvalid and i_bus_err are both high in WAIT, the error SHALL take priority.
REQ-026 i_bus_rvalid and i_bus_err SHALL be ignored outside WAIT.
REQ-027 i_rd_cmd SHALL be ignored in REQ and WAIT.
REQ-028 Minimum latency: i_rd_cmd at cycle 0, ready at cycle 1, rvalid at cycle 2 -> o_busy high in cycles 0-2, low in cycle 3, and o_instr_dat valid from cycle 3.
REQ-029 o_instr_dat SHALL hold its value until the next completed response.

Reset
REQ-030 On nrst=0 the block SHALL asynchronously enter IDLE, with o_instr_dat=0, o_bus_addr=0, o_bus_rd=0, o_err_align=0 and o_err_bus=0.
REQ-031 Reset in REQ or WAIT SHALL abandon the transaction; a late response after reset SHALL be ignored, because it arrives outside WAIT.

Configuration
REQ-032 With UPARC_IFU_LASTHIT_EN defined, the block SHALL keep a tag register (AW) and a valid bit, both cleared at reset.
REQ-033 With the feature enabled, each completed i_bus_rvalid SHALL set tag=o_bus_addr and valid=1, and each i_bus_err SHALL clear valid.
REQ-034 With the feature enabled, hit SHALL be i_rd_cmd AND aligned AND valid AND (i_addr==tag), in IDLE only.
REQ-035 On a hit, the block SHALL keep o_busy low, start no bus transaction and leave o_instr_dat unchanged.
REQ-036 Without UPARC_IFU_LASTHIT_EN defined, the block SHALL contain no tag logic, and every aligned i_rd_cmd SHALL go to the bus.

Verification
REQ-037 Scenario: rd_cmd addr=0x100, ready=1 at cycle 1, rvalid at cycle 2 with data 0x2408_0005 -> o_bus_rd high only in cycle 1, o_busy high in cycles 0-2, o_instr_dat=0x2408_0005 at cycle 3.
REQ-038 Scenario: rd_cmd addr=0x102 -> o_busy=0, o_err_align=1 in cycle 1 only, o_bus_rd never high.
REQ-039 Scenario: ready held low for 4 cycles, then rvalid -> o_bus_rd and o_bus_addr stable for all 4 cycles, o_busy high throughout.
REQ-040 Scenario: i_bus_err in WAIT -> o_instr_dat=0, o_err_bus pulses 1 cycle, FSM returns to IDLE, and a later fetch completes normally.
REQ-041 Scenario: nrst low in WAIT, then rvalid after release -> outputs at reset values, o_instr_dat stays 0.
REQ-042 Scenario (UPARC_IFU_LASTHIT_EN defined): fetch 0x200 twice -> the second fetch has o_busy=0 and no o_bus_rd; after a bus error on 0x200, the next fetch of 0x200 goes to the bus.
